// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character writer.
// Init-sequence helpers are only referenced when LCD_INIT_SEQ_EN is defined.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_INIT_WAIT = 3'd0,
    ST_INIT_CMD  = 3'd1,
    ST_IDLE      = 3'd2,
    ST_SETUP     = 3'd3,
    ST_PULSE     = 3'd4,
    ST_HOLD      = 3'd5,
    ST_WAIT      = 3'd6
  } lcd_state_e;

  localparam int LCD_RS_BIT = 8;

  localparam logic [7:0] LCD_FUNC_SET   = 8'h38;
  localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
  localparam logic [7:0] LCD_CLEAR      = 8'h01;
  localparam logic [7:0] LCD_ENTRY_MODE = 8'h06;
  localparam logic [7:0] LCD_HOME       = 8'h02;

  localparam int LCD_INIT_SEQ_LEN = 4;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_FUNC_SET;
      2'd1:    cmd = LCD_DISP_ON;
      2'd2:    cmd = LCD_CLEAR;
      default: cmd = LCD_ENTRY_MODE;
    endcase
    return cmd;
  endfunction

  // Clear and return-home (0x02 and its don't-care twin 0x03) need the long execution delay.
  function automatic logic is_long_cmd(input logic [8:0] word);
    return !word[LCD_RS_BIT] &&
           ((word[7:0] == LCD_CLEAR) || (word[7:0] == LCD_HOME) || (word[7:0] == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_char_writer_if.sv
// Valid/ready word channel into the LCD writer: {rs, byte} plus handshake.
interface lcd_char_writer_if;
  logic [8:0] in_char;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_char, output in_valid, input in_ready);
  modport slave  (input in_char, input in_valid, output in_ready);
endinterface

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter; o_done flags the last cycle of a loaded interval (count == 1).
module lcd_delay_counter #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  // Load has priority; the count parks at 1 so done stays asserted until the next load.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count > WIDTH'(1)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_done = (r_count == WIDTH'(1));

endmodule

// File: rtl/lcd_char_writer.sv
// 8-bit write-only HD44780 driver: SETUP / EN pulse / HOLD / execution WAIT per accepted word.
// Define LCD_INIT_SEQ_EN to run the power-on init sequence (0x38, 0x0C, 0x01, 0x06) after reset.
module lcd_char_writer
  import lcd_pkg::*;
#(
  parameter int EN_PULSE_CYCLES     = 12,
  parameter int SHORT_WAIT_CYCLES   = 2500,
  parameter int LONG_WAIT_CYCLES    = 82000,
  parameter int POWERUP_WAIT_CYCLES = 1000000
) (
  input  logic                     clk,
  input  logic                     reset,
  lcd_char_writer_if.slave         in_if,
  output logic                     busy,
  output logic                     init_done,
  output logic [7:0]               lcd_data,
  output logic                     lcd_rs,
  output logic                     lcd_rw,
  output logic                     lcd_en
);

  localparam int MAX_A   = (EN_PULSE_CYCLES > SHORT_WAIT_CYCLES) ? EN_PULSE_CYCLES : SHORT_WAIT_CYCLES;
  localparam int MAX_B   = (LONG_WAIT_CYCLES > POWERUP_WAIT_CYCLES) ? LONG_WAIT_CYCLES : POWERUP_WAIT_CYCLES;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

`ifdef LCD_INIT_SEQ_EN
  localparam lcd_state_e RESET_STATE = ST_INIT_WAIT;
`else
  localparam lcd_state_e RESET_STATE = ST_IDLE;
`endif

  lcd_state_e       r_state;
  lcd_state_e       w_state_next;
  lcd_state_e       w_load_target;
  logic [8:0]       r_word;
  logic [8:0]       w_setup_word;
  logic [7:0]       r_lcd_data;
  logic             r_lcd_rs;
  logic             r_lcd_en;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_done;
  logic             w_last_init;

`ifdef LCD_INIT_SEQ_EN
  logic [1:0]       r_init_idx;
  logic             r_init_done;
  assign w_last_init = (r_init_idx == 2'(LCD_INIT_SEQ_LEN - 1));
`else
  assign w_last_init = 1'b0;
`endif

  lcd_delay_counter #(.WIDTH(CNT_W)) u_delay (
    .clk        (clk),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_comb begin
    w_state_next = r_state;
    w_setup_word = r_word;
    case (r_state)
`ifdef LCD_INIT_SEQ_EN
      ST_INIT_WAIT: if (w_done) w_state_next = ST_INIT_CMD;
      ST_INIT_CMD: begin
        w_setup_word = {1'b0, init_cmd(r_init_idx)};
        w_state_next = ST_SETUP;
      end
`endif
      ST_IDLE: begin
        w_setup_word = in_if.in_char;
        if (in_if.in_valid) w_state_next = ST_SETUP;
      end
      ST_SETUP: if (w_done) w_state_next = ST_PULSE;
      ST_PULSE: if (w_done) w_state_next = ST_HOLD;
      ST_HOLD:  if (w_done) w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (w_done) begin
`ifdef LCD_INIT_SEQ_EN
          w_state_next = (r_init_done || w_last_init) ? ST_IDLE : ST_INIT_CMD;
`else
          w_state_next = ST_IDLE;
`endif
        end
      end
      default: w_state_next = RESET_STATE;
    endcase
  end

  // Counter is reloaded on every state change; reset loads the value for the reset state.
  always_comb begin
    w_load_target = reset ? RESET_STATE : w_state_next;
    w_load        = reset || (w_state_next != r_state);
    case (w_load_target)
      ST_INIT_WAIT: w_load_val = CNT_W'(POWERUP_WAIT_CYCLES);
      ST_PULSE:     w_load_val = CNT_W'(EN_PULSE_CYCLES);
      ST_WAIT:      w_load_val = is_long_cmd(r_word) ? CNT_W'(LONG_WAIT_CYCLES)
                                                     : CNT_W'(SHORT_WAIT_CYCLES);
      default:      w_load_val = CNT_W'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RESET_STATE;
      r_word     <= '0;
      r_lcd_data <= '0;
      r_lcd_rs   <= 1'b0;
      r_lcd_en   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_lcd_en <= (w_state_next == ST_PULSE);
      if ((w_state_next == ST_SETUP) && (r_state != ST_SETUP)) begin
        r_word     <= w_setup_word;
        r_lcd_rs   <= w_setup_word[LCD_RS_BIT];
        r_lcd_data <= w_setup_word[7:0];
      end
    end
  end

`ifdef LCD_INIT_SEQ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
    end else if ((r_state == ST_WAIT) && w_done && !r_init_done) begin
      if (w_last_init) r_init_done <= 1'b1;
      else             r_init_idx  <= r_init_idx + 2'd1;
    end
  end
  assign init_done = r_init_done;
`else
  assign init_done = 1'b1;
`endif

  assign in_if.in_ready = (r_state == ST_IDLE) && !reset;
  assign busy           = (r_state != ST_IDLE);
  assign lcd_data       = r_lcd_data;
  assign lcd_rs         = r_lcd_rs;
  assign lcd_rw         = 1'b0;
  assign lcd_en         = r_lcd_en;

endmodule

// File: tb/tb_lcd_char_writer.sv
// Self-checking bench for lcd_char_writer: vector table + EN-pulse scoreboard.
// Define LCD_INIT_SEQ_EN to also exercise the power-on init sequence.
module tb_lcd_char_writer;

  localparam int P  = 2;
  localparam int SW = 4;
  localparam int LW = 8;
  localparam int PW = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy, init_done, lcd_rs, lcd_rw, lcd_en;
  logic [7:0] lcd_data;

  lcd_char_writer_if bus();

  lcd_char_writer #(
    .EN_PULSE_CYCLES(P), .SHORT_WAIT_CYCLES(SW),
    .LONG_WAIT_CYCLES(LW), .POWERUP_WAIT_CYCLES(PW)
  ) dut (
    .clk(clk), .reset(reset), .in_if(bus), .busy(busy), .init_done(init_done),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [8:0] sb[$];
  logic prev_en = 1'b0;
  int en_len = 0;
  int en_start = 0;
  logic skip_len = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Every rising EN must match the next expected word; every pulse must last P cycles.
  always @(negedge clk) begin
    if (lcd_en && !prev_en) begin
      en_start = cyc;
      en_len = 1;
      if (sb.size() == 0) begin
        check("unexpected_en_pulse", {23'd0, lcd_rs, lcd_data}, 32'h3ff);
      end else begin
        logic [8:0] exp_w;
        exp_w = sb.pop_front();
        check("en_word", {23'd0, lcd_rs, lcd_data}, {23'd0, exp_w});
        $display("pulse rs=%0d data=0x%02h cyc=%0d", lcd_rs, lcd_data, cyc);
      end
    end else if (lcd_en) begin
      en_len++;
    end else if (prev_en && !skip_len) begin
      check("en_len", en_len, P);
    end
    prev_en = lcd_en;
  end

  typedef struct {
    logic [8:0] w;
    int         exp_low;
  } vec_t;

  vec_t vecs[7];

  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic send(input logic [8:0] w, output int acc);
    int guard = 0;
    bus.in_char = w;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("accept_timeout", 0, 1);
    acc = cyc;
    sb.push_back(w);
    @(negedge clk);
  endtask

  task automatic wait_ready(input string name);
    int guard = 0;
    while (!bus.in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check(name, 0, 1);
  endtask

`ifdef LCD_INIT_SEQ_EN
  task automatic do_init();
    int guard = 0;
    int bad = 0;
    sb.push_back(9'h038);
    sb.push_back(9'h00C);
    sb.push_back(9'h001);
    sb.push_back(9'h006);
    while (!init_done && guard < 500) begin
      if (bus.in_ready) bad++;
      @(negedge clk);
      guard++;
    end
    check("init_done_rise", init_done, 1);
    check("init_ready_low", bad, 0);
    check("init_ready_after", bus.in_ready, 1);
    check("init_all_words", sb.size(), 0);
    $display("init sequence finished cyc=%0d", cyc);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, cnt;
    vecs[0] = '{9'h141, 2 + P + SW};
    vecs[1] = '{9'h001, 2 + P + LW};
    vecs[2] = '{9'h002, 2 + P + LW};
    vecs[3] = '{9'h003, 2 + P + LW};
    vecs[4] = '{9'h004, 2 + P + SW};
    vecs[5] = '{9'h101, 2 + P + SW};
    vecs[6] = '{9'h080, 2 + P + SW};

    bus.in_char = '0;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en", lcd_en, 0);
    check("rst_data", lcd_data, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_ready", bus.in_ready, 0);
`ifdef LCD_INIT_SEQ_EN
    check("rst_init_done", init_done, 0);
    reset = 1'b0;
    do_init();
`else
    check("rst_busy", busy, 0);
    check("rst_init_done", init_done, 1);
    reset = 1'b0;
    @(negedge clk);
`endif

    for (int i = 0; i < 7; i++) begin
      send(vecs[i].w, acc);
      bus.in_valid = 1'b0;
      check("setup_en", lcd_en, 0);
      check("setup_rs", lcd_rs, vecs[i].w[8]);
      check("setup_data", lcd_data, vecs[i].w[7:0]);
      cnt = 0;
      while (!bus.in_ready && cnt < 100) begin
        cnt++;
        @(negedge clk);
      end
      check("ready_low_cycles", cnt, vecs[i].exp_low);
      check("en_start_cycle", en_start, acc + 2);
      $display("vec %0d word=0x%03h ready_low=%0d", i, vecs[i].w, cnt);
    end

    // Back-to-back with in_valid held high.
    send(9'h130, acc);
    send(9'h131, acc2);
    bus.in_valid = 1'b0;
    check("b2b_spacing", acc2 - acc, 3 + P + SW);
    wait_ready("b2b_drain_timeout");
    $display("b2b spacing=%0d", acc2 - acc);

    // in_valid toggling while busy must not launch extra writes.
    send(9'h1AA, acc);
    bus.in_char = 9'h1BB;
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = (i % 2 == 0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_ready("toggle_drain_timeout");
    repeat (20) @(negedge clk);
    check("toggle_sb_empty", sb.size(), 0);
    $display("toggle test done");

    // Reset in the middle of PULSE.
    send(9'h155, acc);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("midrst_en_high", lcd_en, 1);
    skip_len = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_en", lcd_en, 0);
    check("midrst_data", lcd_data, 0);
    check("midrst_rs", lcd_rs, 0);
    check("midrst_ready", bus.in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    skip_len = 1'b0;
`ifdef LCD_INIT_SEQ_EN
    do_init();
`else
    check("postrst_ready", bus.in_ready, 1);
`endif
    $display("mid-pulse reset done");

    send(9'h142, acc);
    bus.in_valid = 1'b0;
    wait_ready("final_drain_timeout");
    repeat (4) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
